if_fetch_queue: RTL

Parametrised instruction-fetch stage with a DEPTH-entry in-order fetch queue between the pre-fetch stage / I-cache and the decode stage. It replaces the single-register fetch stage: it tolerates multiple outstanding I-cache requests, absorbs decode back-pressure without stalling the cache, and raises AdEL for misaligned PCs. On flush it discards queued instructions and drops in-flight cache responses.

---
 rtl/if_fetch_queue_if.sv | 31 +++
 rtl/if_fetch_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: pre-fetch request, I-cache response,
// flush and the decode-side valid/allowin pair.
// master: pre-fetch / I-cache / decode environment; slave: the fetch queue.
interface if_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ps_valid;
  logic [31:0]   ps_pc;
  logic          ps_bd;
  logic          fs_allowin;
  logic          inst_data_ok;
  logic [31:0]   inst_rdata;
  logic          flush;
  logic          ds_allowin;
  logic          fs_to_ds_valid;
  logic [70:0]   fs_to_ds_bus;
  logic [31:0]   fs_pc;
  logic [CW-1:0] fq_count;

  modport master (
    output ps_valid, ps_pc, ps_bd, inst_data_ok, inst_rdata, flush, ds_allowin,
    input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_pc, fq_count
  );

  modport slave (
    input  ps_valid, ps_pc, ps_bd, inst_data_ok, inst_rdata, flush, ds_allowin,
    output fs_allowin, fs_to_ds_valid, fs_to_ds_bus, fs_pc, fq_count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue between pre-fetch/I-cache and decode.
// Tracks outstanding cache requests, drops responses belonging to flushed
// requests, and tags misaligned PCs with AdEL.
// Optional: define IF_FQ_BYPASS_EN to forward a returning instruction straight
// to decode when it belongs to the head entry.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'hbfbffffc,
  parameter logic [4:0]  EXC_NONE = 5'h1f
) (
  input  logic           clk,
  input  logic           resetn,
  if_fetch_queue_if.slave fq
);
  localparam int         AW       = $clog2(DEPTH);
  localparam int         CW       = AW + 1;
  localparam logic [4:0] EXC_ADEL = 5'h04;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [DEPTH-1:0] bd_q, bd_d;
  logic [DEPTH-1:0] ex_q, ex_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [31:0]      fs_pc_q, fs_pc_d;

  logic             fill_found;
  logic [AW-1:0]    fill_idx;
  logic [CW-1:0]    pend_cnt;
  logic             head_unfilled;
  logic             bypass_hit;
  logic             resp_drop;
  logic             resp_fill;
  logic             accept;
  logic             pop;
  logic [31:0]      head_inst;

  // Locate the oldest unfilled aligned entry and count all unfilled entries.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = head_q;
    pend_cnt   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && !filled_q[head_q + AW'(i)]) begin
        pend_cnt = pend_cnt + CW'(1);
        if (!fill_found) begin
          fill_found = 1'b1;
          fill_idx   = head_q + AW'(i);
        end
      end
    end
  end

  // Handshake outputs and response classification.
  always_comb begin
    head_unfilled = (count_q != '0) && !filled_q[head_q];
    resp_drop     = fq.inst_data_ok && (drop_q != '0);
    resp_fill     = fq.inst_data_ok && (drop_q == '0) && fill_found;
`ifdef IF_FQ_BYPASS_EN
    bypass_hit    = resp_fill && head_unfilled;
`else
    bypass_hit    = 1'b0;
`endif
    fq.fs_allowin     = !fq.flush &&
                        (({1'b0, count_q} + {1'b0, drop_q}) < (CW + 1)'(DEPTH));
    fq.fs_to_ds_valid = !fq.flush && (count_q != '0) &&
                        (filled_q[head_q] || bypass_hit);
    accept            = fq.ps_valid && fq.fs_allowin;
    pop               = fq.fs_to_ds_valid && fq.ds_allowin;
    head_inst         = ex_q[head_q] ? '0 :
                        (bypass_hit ? fq.inst_rdata : inst_q[head_q]);
    fq.fs_to_ds_bus   = {ex_q[head_q], (ex_q[head_q] ? EXC_ADEL : EXC_NONE),
                         bd_q[head_q], head_inst, pc_q[head_q]};
    fq.fs_pc          = fs_pc_q;
    fq.fq_count       = count_q;
  end

  // Next-state: fill, then either flush or accept/dequeue.
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    bd_d     = bd_q;
    ex_d     = ex_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    drop_d   = drop_q - CW'(resp_drop);
    fs_pc_d  = fs_pc_q;

    // A bypassed entry that pops this cycle never needs its slot written.
    if (resp_fill && !(bypass_hit && pop)) begin
      filled_d[fill_idx] = 1'b1;
      inst_d[fill_idx]   = fq.inst_rdata;
    end

    if (fq.flush) begin
      // The response of this cycle is consumed first; every request still
      // unfilled after that has a response in flight that must be dropped.
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      drop_d   = drop_q - CW'(resp_drop) + pend_cnt - CW'(resp_fill);
    end else begin
      if (accept) begin
        pc_d[tail_q]     = fq.ps_pc;
        bd_d[tail_q]     = fq.ps_bd;
        ex_d[tail_q]     = |fq.ps_pc[1:0];
        filled_d[tail_q] = |fq.ps_pc[1:0];
        inst_d[tail_q]   = '0;
        tail_d           = tail_q + AW'(1);
        fs_pc_d          = fq.ps_pc;
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      bd_q     <= '0;
      ex_q     <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      fs_pc_q  <= PC_RESET;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      bd_q     <= bd_d;
      ex_q     <= ex_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      fs_pc_q  <= fs_pc_d;
    end
  end
endmodule
